// File: rtl/iic_axil_pkg.sv
// iic_axil_pkg: FSM states, AXI response codes and IIC register offsets shared by iic_axil_master
package iic_axil_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [8:0] REG_GIE     = 9'h01C;
  localparam logic [8:0] REG_ISR     = 9'h020;
  localparam logic [8:0] REG_SOFTR   = 9'h040;
  localparam logic [8:0] REG_CR      = 9'h100;
  localparam logic [8:0] REG_SR      = 9'h104;
  localparam logic [8:0] REG_TX_FIFO = 9'h108;
  localparam logic [8:0] REG_RX_FIFO = 9'h10C;
  function automatic logic is_busy(input state_t s);
    return s inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
  endfunction
endpackage

// File: rtl/axil_valid_hold.sv
// axil_valid_hold: one AXI-Lite valid plus payload, raised on load and held until its ready
module axil_valid_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) valid <= 1'b0;
endmodule

// File: rtl/iic_axil_master.sv
// iic_axil_master: single-outstanding command/response to AXI4-Lite master; IIC_AXIL_TIMEOUT_EN adds a sticky watchdog
module iic_axil_master
  import iic_axil_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
`ifdef IIC_AXIL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [1:0]          rsp_resp,
  output logic                rsp_write,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
`ifdef IIC_AXIL_TIMEOUT_EN
  , output logic              timeout_err
`endif
);
  state_t state, state_n;
  logic cmd_fire, aw_done, w_done, late;
  assign cmd_fire     = cmd_valid & cmd_ready;
  assign aw_done      = !m_axi_awvalid || m_axi_awready;
  assign w_done       = !m_axi_wvalid || m_axi_wready;
  assign m_axi_bready = state == WR_RESP;
  assign m_axi_rready = state == RD_RESP;
  assign rsp_valid    = state == RSP;
  axil_valid_hold #(.W(ADDR_W)) u_aw (
    .clk, .aresetn, .load(cmd_fire & cmd_write), .d(cmd_addr), .ready(m_axi_awready),
    .valid(m_axi_awvalid), .q(m_axi_awaddr)
  );
  axil_valid_hold #(.W(DATA_W + DATA_W/8)) u_w (
    .clk, .aresetn, .load(cmd_fire & cmd_write), .d({cmd_wstrb, cmd_wdata}), .ready(m_axi_wready),
    .valid(m_axi_wvalid), .q({m_axi_wstrb, m_axi_wdata})
  );
  axil_valid_hold #(.W(ADDR_W)) u_ar (
    .clk, .aresetn, .load(cmd_fire & ~cmd_write), .d(cmd_addr), .ready(m_axi_arready),
    .valid(m_axi_arvalid), .q(m_axi_araddr)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_fire) state_n = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_done && w_done) state_n = WR_RESP;
      WR_RESP: if (m_axi_bvalid) state_n = RSP;
      RD_REQ:  if (m_axi_arready) state_n = RD_RESP;
      RD_RESP: if (m_axi_rvalid) state_n = RSP;
      RSP:     if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // cmd_ready is registered so it stays low in reset and re-opens only after the response handshake
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_n;
      cmd_ready <= state_n == IDLE;
    end
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      rsp_data  <= '0;
      rsp_resp  <= OKAY;
      rsp_write <= 1'b0;
    end else if (m_axi_bready && m_axi_bvalid) begin
      rsp_data  <= '0;
      rsp_resp  <= late ? SLVERR : m_axi_bresp;
      rsp_write <= 1'b1;
    end else if (m_axi_rready && m_axi_rvalid) begin
      rsp_data  <= m_axi_rdata;
      rsp_resp  <= late ? SLVERR : m_axi_rresp;
      rsp_write <= 1'b0;
    end
`ifdef IIC_AXIL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  logic err_q, hit;
  // hit marks the TIMEOUT_CYCLES-th busy cycle after acceptance; the flag shows it that same cycle
  assign hit         = is_busy(state) && cnt == LIMIT - 1'b1;
  assign late        = cnt >= LIMIT - 1'b1;
  assign timeout_err = err_q | hit;
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= cmd_fire ? '0 : (is_busy(state) && cnt != LIMIT) ? cnt + 1'b1 : cnt;
      err_q <= err_q | hit;
    end
`else
  assign late = 1'b0;
`endif
endmodule
